// File: rtl/m_iter_divider.sv
// m_iter_divider: radix-2 restoring integer divide/remainder unit.
// It produces one quotient bit per clock behind a valid/ready handshake.
// Divide-by-zero and signed overflow follow the RISC-V M-extension results.
//
// state  | meaning
// S_IDLE | waiting for a request; o_ready high, outputs hold last result
// S_CALC | iterating; one quotient bit per edge, counter runs WIDTH..1
// S_DONE | result presented on o_valid until i_ready is seen
module m_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dbz
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             is_dbz, is_ovf;
  logic [WIDTH:0]   rem_shift, rem_trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, quot_next;

  assign o_ready     = (state_q == S_IDLE) && !i_reset;
  assign o_valid     = valid_q;
  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;
  assign o_dbz       = dbz_q;

  // Next-state, datapath iteration and output register inputs.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    accept  = i_valid && o_ready;
    dvd_neg = i_signed & i_dividend[WIDTH-1];
    dvs_neg = i_signed & i_divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    dvs_mag = dvs_neg ? -i_divisor : i_divisor;
    is_dbz  = (i_divisor == '0);
    is_ovf  = i_signed && (i_dividend == MIN_NEG) && (i_divisor == '1);

    // Restoring step: a set MSB in the shifted remainder already exceeds any
    // WIDTH-bit divisor, otherwise the trial sign decides.
    rem_shift = {rem_q, quot_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, dvsr_q};
    q_bit     = rem_shift[WIDTH] | ~rem_trial[WIDTH];
    rem_next  = q_bit ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], q_bit};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_dbz) begin
            quotient_d  = '1;
            remainder_d = i_dividend;
            dbz_d       = 1'b1;
            valid_d     = 1'b1;
            state_d     = S_DONE;
          end else if (is_ovf) begin
            quotient_d  = i_dividend;
            remainder_d = '0;
            dbz_d       = 1'b0;
            valid_d     = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d      = '0;
            quot_d     = dvd_mag;
            dvsr_d     = dvs_mag;
            neg_quot_d = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
            cnt_d      = CNT_INIT;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d  = rem_next;
        quot_d = quot_next;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          quotient_d  = neg_quot_q ? -quot_next : quot_next;
          remainder_d = neg_rem_q ? -rem_next : rem_next;
          dbz_d       = 1'b0;
          valid_d     = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, iteration registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule
